pcie_tlp_tx_arbiter: RTL and testbench

Shares the single TX→RX TLP link between N_REQ transaction-layer requesters (e.g. AXI write path, completion path, config path).
- Round-robin arbitration, gated by a link-credit counter.
- Credit is replenished by credit-update DLLPs returned from the RX side.
- Stamps each granted TLP with a 12-bit sequence number.
- Presents the TLP on a registered valid/ready output stage that feeds the TX data-link logic.

---
 rtl/pcie_pkg.sv | 21 ++
 rtl/pcie_rr_picker.sv | 40 ++++
 rtl/pcie_tlp_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_pcie_tlp_tx_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// -----------------------------------------------------------------------------
// pcie_pkg
// Shared definitions for the PCIe TLP transmit/receive slice.
//   DLLP_UPDATEFC  : DLLP type byte of a flow-control credit update
//   arb_state_t    : output-stage state of the TX arbiter (IDLE / HOLD)
//   SEQ_W_DEFAULT  : default TLP sequence number width
//   CRD_W_DEFAULT  : default link-credit counter width
// -----------------------------------------------------------------------------
package pcie_pkg;

  localparam logic [7:0] DLLP_UPDATEFC = 8'h80;

  localparam int SEQ_W_DEFAULT = 12;
  localparam int CRD_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pcie_rr_picker.sv
// -----------------------------------------------------------------------------
// pcie_rr_picker
// Combinational round-robin picker. Searches req starting at last+1 (modulo
// N_REQ) and returns the first asserted requester.
// Ports:
//   req  in  N_REQ  request vector
//   last in  IDX_W  index of the previous winner
//   gnt  out N_REQ  one-hot grant (all zero when no request)
//   idx  out IDX_W  encoded grant index (0 when no request)
//   any  out 1      at least one request present
// -----------------------------------------------------------------------------
module pcie_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Offset 1 is checked first so the previous winner is considered last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/pcie_tlp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pcie_tlp_tx_arbiter
// Shares the TX TLP link between N_REQ transaction-layer requesters.
// Round-robin arbitration gated by a link-credit counter; credits are returned
// by UpdateFC DLLPs. Each granted TLP is stamped with a wrapping sequence
// number and presented on a registered valid/ready output stage.
//
// Build option: define PCIE_TLP_ARB_PRIO_EN to give requester 0 strict
// priority (requesters 1..N_REQ-1 then round-robin among themselves).
//
// Ports:
//   clk          in   1             rising-edge clock
//   rst          in   1             synchronous active-high reset
//   req_valid_i  in   N_REQ         per-requester TLP valid
//   req_data_i   in   N_REQ*DATA_W  requester k at [k*DATA_W +: DATA_W]
//   req_ready_o  out  N_REQ         one-hot accept strobe (combinational)
//   tlp_valid_o  out  1             output TLP valid
//   tlp_ready_i  in   1             downstream accept
//   tlp_data_o   out  DATA_W        granted TLP
//   tlp_seq_o    out  SEQ_W         sequence number of tlp_data_o
//   grant_id_o   out  clog2(N_REQ)  requester index of tlp_data_o
//   crd_valid_i  in   1             credit-update DLLP valid
//   crd_dllp_i   in   32            DLLP: [31:24] type, [7:0] credit increment
//   crd_ready_o  out  1             credit-update accept (high out of reset)
//   crd_avail_o  out  CRD_W         current credit count
// -----------------------------------------------------------------------------
module pcie_tlp_tx_arbiter
  import pcie_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int DATA_W   = 1024,
  parameter int CRD_W    = CRD_W_DEFAULT,
  parameter int CRD_INIT = 16,
  parameter int SEQ_W    = SEQ_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]    req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       tlp_valid_o,
  input  logic                       tlp_ready_i,
  output logic [DATA_W-1:0]          tlp_data_o,
  output logic [SEQ_W-1:0]           tlp_seq_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  input  logic                       crd_valid_i,
  input  logic [31:0]                crd_dllp_i,
  output logic                       crd_ready_o,
  output logic [CRD_W-1:0]           crd_avail_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SUM_W = ((CRD_W > 8) ? CRD_W : 8) + 2;
  localparam logic [CRD_W-1:0] CRD_MAX = {CRD_W{1'b1}};

  // cnt - dec + inc, clamped at the counter maximum. dec is only set when
  // cnt is non-zero, so the intermediate never underflows.
  function automatic logic [CRD_W-1:0] sat_credit(input logic [CRD_W-1:0] cnt,
                                                  input logic             dec,
                                                  input logic [7:0]       inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc) - SUM_W'(dec);
    if (sum > SUM_W'(CRD_MAX)) return CRD_MAX;
    return sum[CRD_W-1:0];
  endfunction

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q;
  logic [CRD_W-1:0]  crd_cnt;
  logic [SEQ_W-1:0]  seq_cnt;

  logic [N_REQ-1:0]  pick_req, pick_gnt, gnt;
  logic [IDX_W-1:0]  pick_idx, win_idx;
  logic              pick_any, any_req, upd_last;
  logic              load;
  logic [7:0]        crd_inc;
  logic              dllp_unused;

  logic [DATA_W-1:0] data_p1;
  logic [SEQ_W-1:0]  seq_p1;
  logic [IDX_W-1:0]  gid_p1;
  logic              vld_p1;

  // ---------------------------------------------------------------------------
  // Stage p0: arbitration, credit gate and accept strobe
  // ---------------------------------------------------------------------------
  pcie_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req  (pick_req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef PCIE_TLP_ARB_PRIO_EN
  // Requester 0 bypasses the ring; the picker only sees 1..N_REQ-1.
  assign pick_req = {req_valid_i[N_REQ-1:1], 1'b0};
  assign any_req  = req_valid_i[0] | pick_any;

  always_comb begin
    gnt      = pick_gnt;
    win_idx  = pick_idx;
    upd_last = 1'b1;
    if (req_valid_i[0]) begin
      gnt      = N_REQ'(1);
      win_idx  = '0;
      upd_last = 1'b0;
    end
  end
`else
  assign pick_req = req_valid_i;
  assign any_req  = pick_any;
  assign gnt      = pick_gnt;
  assign win_idx  = pick_idx;
  assign upd_last = 1'b1;
`endif

  assign load = !rst && any_req && (crd_cnt != '0) &&
                (state_q == IDLE || tlp_ready_i);

  assign req_ready_o = load ? gnt : '0;

  assign crd_ready_o = !rst;
  assign crd_inc     = (crd_valid_i && !rst && crd_dllp_i[31:24] == DLLP_UPDATEFC)
                       ? crd_dllp_i[7:0] : 8'd0;
  assign dllp_unused = ^crd_dllp_i[23:8];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = HOLD;
      HOLD:    if (tlp_ready_i && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    vld_p1 = (state_q == HOLD);
  end

  // Arbiter bookkeeping: RR pointer, sequence counter, link credits
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= IDX_W'(N_REQ - 1);
      seq_cnt <= '0;
      crd_cnt <= CRD_W'(CRD_INIT);
    end else begin
      if (load && upd_last) last_q <= win_idx;
      if (load)             seq_cnt <= seq_cnt + 1'b1;
      crd_cnt <= sat_credit(crd_cnt, load, crd_inc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered output TLP, held stable while in HOLD without ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      seq_p1  <= '0;
      gid_p1  <= '0;
    end else if (load) begin
      data_p1 <= req_data_i[int'(win_idx)*DATA_W +: DATA_W];
      seq_p1  <= seq_cnt;
      gid_p1  <= win_idx;
    end
  end

  assign tlp_valid_o = vld_p1;
  assign tlp_data_o  = data_p1;
  assign tlp_seq_o   = seq_p1;
  assign grant_id_o  = gid_p1;
  assign crd_avail_o = crd_cnt;

endmodule

// File: tb/tb_pcie_tlp_tx_arbiter.sv
module tb_pcie_tlp_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready_o;
  logic              tlp_valid_o;
  logic              tlp_ready;
  logic [DW-1:0]     tlp_data_o;
  logic [11:0]       tlp_seq_o;
  logic [1:0]        grant_id_o;
  logic              crd_valid;
  logic [31:0]       crd_dllp;
  logic              crd_ready_o;
  logic [7:0]        crd_avail_o;

  int n_chk  = 0;
  int n_fail = 0;

  pcie_tlp_tx_arbiter #(
    .N_REQ(N), .DATA_W(DW), .CRD_W(8), .CRD_INIT(16), .SEQ_W(12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .tlp_valid_o (tlp_valid_o),
    .tlp_ready_i (tlp_ready),
    .tlp_data_o  (tlp_data_o),
    .tlp_seq_o   (tlp_seq_o),
    .grant_id_o  (grant_id_o),
    .crd_valid_i (crd_valid),
    .crd_dllp_i  (crd_dllp),
    .crd_ready_o (crd_ready_o),
    .crd_avail_o (crd_avail_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(k);
    return {32{w}};
  endfunction

  task automatic drive_idle();
    req_valid = '0;
    tlp_ready = 1'b0;
    crd_valid = 1'b0;
    crd_dllp  = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    req_valid = 3'b111;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (crd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_crd_ready: got %b expected 0", crd_ready_o);
    end
    n_chk++;
    if (req_ready_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 000", req_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b0 || tlp_seq_o !== 12'd0 || grant_id_o !== 2'd0 ||
        tlp_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b seq=%0d gid=%0d data[31:0]=%h expected 0,0,0,0",
               tlp_valid_o, tlp_seq_o, grant_id_o, tlp_data_o[31:0]);
    end
    n_chk++;
    if (crd_avail_o !== 8'd16 || crd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_credit: got avail=%0d ready=%b expected 16,1", crd_avail_o, crd_ready_o);
    end
  endtask

`ifndef PCIE_TLP_ARB_PRIO_EN
  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    apply_reset();
    req_valid = 3'b111;
    tlp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_rdy = 3'(1 << (i % 3));
      n_chk++;
      if (req_ready_o !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready_o, exp_rdy);
      end
      if (i > 0) begin
        n_chk++;
        if (tlp_valid_o !== 1'b1 || grant_id_o !== 2'((i - 1) % 3) ||
            tlp_seq_o !== 12'(i - 1) || tlp_data_o !== pat((i - 1) % 3)) begin
          n_fail++;
          $display("FAIL rr_out[%0d]: got v=%b gid=%0d seq=%0d d=%h expected 1,%0d,%0d,%h",
                   i, tlp_valid_o, grant_id_o, tlp_seq_o, tlp_data_o[31:0],
                   (i - 1) % 3, i - 1, pat((i - 1) % 3) & 32'hFFFF_FFFF);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b1 || grant_id_o !== 2'd0 || tlp_seq_o !== 12'd3 ||
        crd_avail_o !== 8'd12) begin
      n_fail++;
      $display("FAIL rr_last: got v=%b gid=%0d seq=%0d crd=%0d expected 1,0,3,12",
               tlp_valid_o, grant_id_o, tlp_seq_o, crd_avail_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b0 || crd_avail_o !== 8'd12) begin
      n_fail++;
      $display("FAIL rr_drain: got v=%b crd=%0d expected 0,12", tlp_valid_o, crd_avail_o);
    end
  endtask
`endif

`ifdef PCIE_TLP_ARB_PRIO_EN
  task automatic test_priority();
    apply_reset();
    req_valid = 3'b111;
    tlp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready_o !== 3'b001) begin
        n_fail++; $display("FAIL prio_ready[%0d]: got %b expected 001", i, req_ready_o);
      end
      @(posedge clk); #1;
    end
    req_valid = 3'b110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready_o !== ((i % 2 == 0) ? 3'b010 : 3'b100)) begin
        n_fail++;
        $display("FAIL prio_rr[%0d]: got %b expected %b", i, req_ready_o,
                 (i % 2 == 0) ? 3'b010 : 3'b100);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask
`endif

  task automatic test_credit();
    int pulses;
    apply_reset();
    req_valid = 3'b111;
    tlp_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_o !== 3'b000) pulses++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (pulses != 16 || crd_avail_o !== 8'd0) begin
      n_fail++; $display("FAIL credit_drain: got grants=%0d crd=%0d expected 16,0", pulses, crd_avail_o);
    end
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 3'b000 || tlp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_zero_block: got rdy=%b v=%b expected 000,0", req_ready_o, tlp_valid_o);
    end
    @(posedge clk); #1;
    crd_valid = 1'b1;
    crd_dllp  = 32'h4000_0005;
    @(posedge clk); #1;
    crd_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (crd_avail_o !== 8'd0 || req_ready_o !== 3'b000) begin
      n_fail++;
      $display("FAIL credit_other_dllp: got crd=%0d rdy=%b expected 0,000", crd_avail_o, req_ready_o);
    end
    @(posedge clk); #1;
    crd_valid = 1'b1;
    crd_dllp  = 32'h8000_0003;
    @(posedge clk); #1;
    crd_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready_o !== 3'b000) pulses++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (pulses != 3 || crd_avail_o !== 8'd0) begin
      n_fail++; $display("FAIL credit_refill: got grants=%0d crd=%0d expected 3,0", pulses, crd_avail_o);
    end
    drive_idle();
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid = 3'b111;
    tlp_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 3'b001) begin
      n_fail++; $display("FAIL stall_first_grant: got %b expected 001", req_ready_o);
    end
    @(posedge clk); #1;
    req_valid = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (tlp_valid_o !== 1'b1 || tlp_seq_o !== 12'd0 || tlp_data_o !== pat(0) ||
          grant_id_o !== 2'd0 || req_ready_o !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b seq=%0d gid=%0d d=%h rdy=%b expected 1,0,0,d0000000,000",
                 i, tlp_valid_o, tlp_seq_o, grant_id_o, tlp_data_o[31:0], req_ready_o);
      end
      @(posedge clk); #1;
    end
    tlp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 3'b010 || grant_id_o !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_release: got rdy=%b gid=%0d expected 010,0", req_ready_o, grant_id_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (grant_id_o !== 2'd1 || tlp_seq_o !== 12'd1 || tlp_data_o !== pat(1) ||
        req_ready_o !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_1: got gid=%0d seq=%0d d=%h rdy=%b expected 1,1,d0000001,100",
               grant_id_o, tlp_seq_o, tlp_data_o[31:0], req_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b1 || grant_id_o !== 2'd2 || tlp_seq_o !== 12'd2) begin
      n_fail++;
      $display("FAIL b2b_2: got v=%b gid=%0d seq=%0d expected 1,2,2", tlp_valid_o, grant_id_o, tlp_seq_o);
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    crd_valid = 1'b1;
    crd_dllp  = 32'h8000_00FF;
    @(posedge clk); #1;
    crd_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (crd_avail_o !== 8'd255) begin
      n_fail++; $display("FAIL sat_big: got %0d expected 255", crd_avail_o);
    end
    @(posedge clk); #1;
    crd_valid = 1'b1;
    crd_dllp  = 32'h8000_000A;
    @(posedge clk); #1;
    crd_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (crd_avail_o !== 8'd255) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected 255", crd_avail_o);
    end
  endtask

  task automatic test_simul_and_seq_wrap();
    bit          found;
    bit          crd_ok;
    logic [7:0]  bad_crd;
    apply_reset();
    req_valid = 3'b111;
    tlp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++;
    if (crd_avail_o !== 8'd5 || tlp_seq_o !== 12'd10) begin
      n_fail++;
      $display("FAIL simul_setup: got crd=%0d seq=%0d expected 5,10", crd_avail_o, tlp_seq_o);
    end
    crd_valid = 1'b1;
    crd_dllp  = 32'h8000_0001;
    found  = 1'b0;
    crd_ok = 1'b1;
    bad_crd = 8'd5;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (crd_avail_o !== 8'd5) begin
        crd_ok  = 1'b0;
        bad_crd = crd_avail_o;
      end
      if (tlp_seq_o === 12'hFFF) found = 1'b1;
    end
    n_chk++;
    if (!crd_ok) begin
      n_fail++; $display("FAIL simul_credit: got %0d expected 5", bad_crd);
    end
    n_chk++;
    if (!found) begin
      n_fail++; $display("FAIL seq_reach_4095: got seq=%0d expected 4095 within 5000 cycles", tlp_seq_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (tlp_seq_o !== 12'd0 || tlp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL seq_wrap: got seq=%0d v=%b expected 0,1", tlp_seq_o, tlp_valid_o);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 3'b010;
    tlp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 3'b111;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b1 || grant_id_o !== 2'd1 || crd_avail_o !== 8'd15) begin
      n_fail++;
      $display("FAIL midrst_setup: got v=%b gid=%0d crd=%0d expected 1,1,15",
               tlp_valid_o, grant_id_o, crd_avail_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 3'b000 || crd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_gate: got rdy=%b crd_rdy=%b expected 000,0", req_ready_o, crd_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tlp_valid_o !== 1'b0 || crd_avail_o !== 8'd16 || tlp_seq_o !== 12'd0 ||
        tlp_data_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b crd=%0d seq=%0d d=%h expected 0,16,0,0",
               tlp_valid_o, crd_avail_o, tlp_seq_o, tlp_data_o[31:0]);
    end
    n_chk++;
    if (req_ready_o !== 3'b001) begin
      n_fail++; $display("FAIL midrst_next_grant: got %b expected 001", req_ready_o);
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = pat(k);
    drive_idle();
    rst = 1'b1;
    test_reset();
`ifndef PCIE_TLP_ARB_PRIO_EN
    test_round_robin();
`else
    test_priority();
`endif
    test_credit();
    test_stall();
    test_saturation();
    test_simul_and_seq_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
